// File: rtl/slon_stream_gen.sv
// rtl/slon_stream_gen.sv - multi-channel test pattern source with divided output clock
// Optional word/underrun statistics counters: define SLON_STREAM_GEN_STATS_EN.
module slon_stream_gen #(
    parameter int                    DOUT_WIDTH = 8,
    parameter int                    CH_NUM     = 2,
    parameter int                    CLK_FACTOR = 8,
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [DOUT_WIDTH-1:0] LFSR_POLY  = 8'hB8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [DOUT_WIDTH-1:0]        seed,
    output logic                         out_clk,
    output logic [CH_NUM*DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         underrun,
    output logic                         busy
`ifdef SLON_STREAM_GEN_STATS_EN
    ,
    output logic [31:0]                  word_cnt,
    output logic [15:0]                  underrun_cnt
`endif
);
    localparam int W  = DOUT_WIDTH;
    localparam int WW = CH_NUM * DOUT_WIDTH;
    localparam int CW = $clog2(CLK_FACTOR);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  div_cnt;
    logic           tick, div_last;
    logic [1:0]     mode_q;
    logic [WW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    level;
    logic           fifo_empty, fifo_full, push, pop;
    logic [WW-1:0]  gen_word;

    assign tick     = (div_cnt == CW'(CLK_FACTOR/2 - 1));
    assign div_last = (div_cnt == CW'(CLK_FACTOR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            out_clk <= 1'b0;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + CW'(1);
            if (tick)
                out_clk <= 1'b1;
            else if (div_last)
                out_clk <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (enable) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   if (!enable) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (enable)
                    state_nx = S_RUN;
                else if (tick && fifo_empty)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= 2'd0;
        else if (state == S_LOAD)
            mode_q <= mode;
    end

    // Each channel holds the word it will push next; it only advances on a push, so a full FIFO stalls it.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        localparam logic [W-1:0] CH_IDX    = W'(k);
        localparam logic [W-1:0] WALK_INIT = W'(1) << (k % W);
        logic [W-1:0] gen_q, gen_init, gen_next, lfsr_init;

        assign lfsr_init = ((seed ^ CH_IDX) == '0) ? W'(1) : (seed ^ CH_IDX);

        always_comb begin
            gen_init = seed;
            gen_next = gen_q;
            case (mode)
                2'd0:    gen_init = seed + CH_IDX;
                2'd1:    gen_init = lfsr_init;
                2'd2:    gen_init = WALK_INIT;
                default: gen_init = seed;
            endcase
            case (mode_q)
                2'd0:    gen_next = gen_q + W'(1);
                2'd1:    gen_next = gen_q[0] ? ((gen_q >> 1) ^ LFSR_POLY) : (gen_q >> 1);
                2'd2:    gen_next = {gen_q[W-2:0], gen_q[W-1]};
                default: gen_next = gen_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                gen_q <= '0;
            else if (state == S_LOAD)
                gen_q <= gen_init;
            else if (push)
                gen_q <= gen_next;
        end

        assign gen_word[k*W +: W] = gen_q;
    end

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
    assign push       = (state == S_RUN) && !fifo_full;
    assign pop        = tick && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= gen_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            underrun   <= 1'b0;
        end else if (tick) begin
            dout_valid <= !fifo_empty;
            if (!fifo_empty)
                dout <= mem[rd_ptr];
            if (fifo_empty && state == S_RUN)
                underrun <= 1'b1;
        end
    end

`ifdef SLON_STREAM_GEN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt     <= '0;
            underrun_cnt <= '0;
        end else if (tick) begin
            if (!fifo_empty)
                word_cnt <= word_cnt + 32'd1;
            if (fifo_empty && state == S_RUN && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_slon_stream_gen.sv
// tb/tb_slon_stream_gen.sv - self-checking bench for slon_stream_gen against a queue-level stream model
module tb_slon_stream_gen;
    localparam int         W     = 8;
    localparam int         CH    = 2;
    localparam int         CF    = 8;
    localparam int         DEPTH = 16;
    localparam logic [7:0] POLY  = 8'hB8;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DRAIN = 3;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            enable = 1'b0;
    logic [1:0]      mode   = 2'd0;
    logic [W-1:0]    seed   = '0;
    logic            out_clk;
    logic [CH*W-1:0] dout;
    logic            dout_valid, underrun, busy;
`ifdef SLON_STREAM_GEN_STATS_EN
    logic [31:0]     word_cnt;
    logic [15:0]     underrun_cnt;
`endif

    int tests = 0;
    int fails = 0;

    int              m_cnt    = 0;
    int              m_phase  = P_IDLE;
    int              m_mode   = 0;
    logic [W-1:0]    m_seed   = '0;
    int              n_gen    = 0;
    logic [CH*W-1:0] m_dout   = '0;
    bit              m_valid  = 1'b0;
    bit              m_under  = 1'b0;
    bit              m_outclk = 1'b0;
    bit              m_tick   = 1'b0;
    longint          m_wcnt   = 0;
    int              m_ucnt   = 0;
    logic [CH*W-1:0] q[$];
    logic [CH*W-1:0] cap[$];

    slon_stream_gen #(
        .DOUT_WIDTH (W),
        .CH_NUM     (CH),
        .CLK_FACTOR (CF),
        .FIFO_DEPTH (DEPTH),
        .LFSR_POLY  (POLY)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .seed         (seed),
        .out_clk      (out_clk),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .underrun     (underrun),
        .busy         (busy)
`ifdef SLON_STREAM_GEN_STATS_EN
        ,
        .word_cnt     (word_cnt),
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word n of the stream straight from the pattern definitions.
    function automatic logic [CH*W-1:0] expect_word(input int md, input logic [W-1:0] sd, input int n);
        logic [CH*W-1:0] w;
        logic [W-1:0]    v;
        w = '0;
        for (int k = 0; k < CH; k++) begin
            case (md)
                0: v = sd + W'(k) + W'(n);
                1: begin
                    v = sd ^ W'(k);
                    if (v == '0) v = W'(1);
                    for (int i = 0; i < n; i++)
                        v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
                end
                2: v = W'(1) << ((n + k) % W);
                default: v = sd;
            endcase
            w[k*W +: W] = v;
        end
        return w;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt = 0; m_phase = P_IDLE; n_gen = 0; m_dout = '0; m_valid = 0;
            m_under = 0; m_outclk = 0; m_tick = 0; m_wcnt = 0; m_ucnt = 0;
            q.delete();
        end else begin
            bit tk, emp, do_push;
            int nx;
            tk      = (m_cnt == CF/2 - 1);
            emp     = (q.size() == 0);
            do_push = (m_phase == P_RUN) && (q.size() < DEPTH);
            m_tick  = tk;
            if (tk) begin
                m_valid = !emp;
                if (!emp) begin
                    m_dout = q.pop_front();
                    m_wcnt++;
                end
                if (emp && m_phase == P_RUN) begin
                    m_under = 1'b1;
                    if (m_ucnt < 16'hFFFF) m_ucnt++;
                end
            end
            if (do_push) begin
                q.push_back(expect_word(m_mode, m_seed, n_gen));
                n_gen++;
            end
            nx = m_phase;
            case (m_phase)
                P_IDLE:  if (enable) nx = P_LOAD;
                P_LOAD:  begin m_mode = int'(mode); m_seed = seed; n_gen = 0; nx = P_RUN; end
                P_RUN:   if (!enable) nx = P_DRAIN;
                default: if (enable) nx = P_RUN; else if (tk && emp) nx = P_IDLE;
            endcase
            m_phase = nx;
            if (m_cnt == CF/2 - 1) m_outclk = 1'b1;
            else if (m_cnt == CF - 1) m_outclk = 1'b0;
            m_cnt = (m_cnt + 1) % CF;
        end
    end

    initial forever begin
        @(negedge clk);
        check("out_clk", 64'(out_clk), 64'(m_outclk));
        check("dout", 64'(dout), 64'(m_dout));
        check("dout_valid", 64'(dout_valid), 64'(m_valid));
        check("underrun", 64'(underrun), 64'(m_under));
        check("busy", 64'(busy), 64'(m_phase != P_IDLE));
`ifdef SLON_STREAM_GEN_STATS_EN
        check("word_cnt", 64'(word_cnt), 64'(m_wcnt[31:0]));
        check("underrun_cnt", 64'(underrun_cnt), 64'(m_ucnt));
`endif
        if (rst_n && m_tick && dout_valid) cap.push_back(dout);
    end

    task automatic wait_phase(input int ph);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != ph && n < 4*CF);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic start_run(input int md, input logic [W-1:0] sd, input int nw, input int ph);
        int n = 0;
        cap.delete();
        mode = 2'(md);
        seed = sd;
        wait_phase(ph);
        enable = 1'b1;
        while (cap.size() < nw && n < nw*CF*2 + 200) begin
            @(negedge clk);
            n++;
        end
        check("words_timeout", 64'(cap.size() >= nw), 64'd1);
        enable = 1'b0;
    endtask

    initial begin
        int hi, rises, zeros, reps;
        bit prev;
        repeat (3) @(negedge clk);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outclk", 64'(out_clk), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        rst_n = 1'b1;

        hi = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_clk) hi++;
            if (out_clk && !prev) rises++;
            prev = out_clk;
        end
        check("outclk_high_cycles", 64'(hi), 64'd20);
        check("outclk_rises", 64'(rises), 64'd5);
        check("idle_valid", 64'(dout_valid), 64'd0);

        start_run(0, 8'h10, 6, 5);
        wait_idle();
        check("cnt_w0", 64'(cap[0]), 64'h1110);
        check("cnt_w1", 64'(cap[1]), 64'h1211);
        check("cnt_w2", 64'(cap[2]), 64'h1312);
        check("cnt_underrun", 64'(underrun), 64'd0);

        start_run(0, 8'hFE, 4, 5);
        wait_idle();
        check("wrap_w0", 64'(cap[0]), 64'hFFFE);
        check("wrap_w1", 64'(cap[1]), 64'h00FF);
        check("wrap_w2", 64'(cap[2]), 64'h0100);

        start_run(1, 8'h00, 300, 5);
        wait_idle();
        check("lfsr_w0", 64'(cap[0]), 64'h0101);
        check("lfsr_w1", 64'(cap[1]), 64'hB8B8);
        check("lfsr_w2", 64'(cap[2]), 64'h5C5C);
        zeros = 0; reps = 0;
        for (int i = 0; i < 300 && i < cap.size(); i++)
            for (int k = 0; k < CH; k++)
                if (cap[i][k*W +: W] == '0) zeros++;
        for (int i = 1; i < 255 && i < cap.size(); i++)
            if (cap[i] == cap[0]) reps++;
        check("lfsr_zero_words", 64'(zeros), 64'd0);
        check("lfsr_early_repeat", 64'(reps), 64'd0);
        check("lfsr_period", 64'(cap[255]), 64'h0101);

        start_run(2, 8'h00, 10, 5);
        wait_idle();
        check("walk_w0", 64'(cap[0]), 64'h0201);
        check("walk_w1", 64'(cap[1]), 64'h0402);
        check("walk_w7", 64'(cap[7]), 64'h0180);
        check("walk_w8", 64'(cap[8]), 64'h0201);

        start_run(0, 8'h40, 5, 5);
        check("drain_busy", 64'(busy), 64'd1);
        wait_idle();
        check("drain_words", 64'(cap.size()), 64'd21);
        check("drain_last", 64'(cap[20]), 64'h5554);
        check("drain_valid", 64'(dout_valid), 64'd0);
        check("drain_underrun", 64'(underrun), 64'd0);

        cap.delete();
        mode = 2'd3;
        seed = 8'hA5;
        wait_phase(1);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        check("under_set", 64'(underrun), 64'd1);
        check("const_w0", 64'(cap[0]), 64'hA5A5);
`ifdef SLON_STREAM_GEN_STATS_EN
        check("under_cnt_one", 64'(underrun_cnt), 64'd1);
        check("word_cnt_ticks", 64'(word_cnt), 64'(m_wcnt[31:0]));
`endif
        repeat (40) @(negedge clk);
        check("under_sticky", 64'(underrun), 64'd1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_dout", 64'(dout), 64'd0);
        check("async_valid", 64'(dout_valid), 64'd0);
        check("async_underrun", 64'(underrun), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_outclk", 64'(out_clk), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
